// File: rtl/cmp_branch_seq_pkg.sv
// Shared definitions for the compare / conditional-branch sequencer.
// Holds the opcode encodings, the FSM state encoding, the default timeout
// and a helper that decides whether a resolved branch loads the PC.
package cmp_branch_seq_pkg;

  // Opcode encodings as issued by the instruction decoder
  localparam logic [1:0] OP_CMP = 2'b00;
  localparam logic [1:0] OP_JZ  = 2'b01;
  localparam logic [1:0] OP_JNZ = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // State encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_CMP     = 2'd2;
  localparam logic [1:0] S_RESOLVE = 2'd3;

  // Default number of REQ cycles tolerated without mem_ack
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    StIdle    = S_IDLE,
    StReq     = S_REQ,
    StCmp     = S_CMP,
    StResolve = S_RESOLVE
  } state_e;

  // A branch is taken for JZ on Z=1 and JNZ on Z=0; CMP and NOP never branch.
  function automatic logic branch_taken(input logic [1:0] op, input logic z);
    return ((op == OP_JZ) && z) || ((op == OP_JNZ) && !z);
  endfunction

endpackage

// File: rtl/cmp_branch_seq_if.sv
// Memory read bus between the sequencer (master) and the memory (slave).
//   mem_req  : read request, held for the whole request phase
//   mem_addr : read address
//   mem_ack  : one-cycle pulse, mem_data valid
//   mem_data : read data
interface cmp_branch_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 8
) ();

  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/cmp_branch_seq_wait_timer.sv
// Wait counter for the memory request phase.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   en_i   : count one more cycle without ack
//   clr_i  : return to zero (wins over en_i)
//   term_o : the current cycle is the MAX_WAIT-th cycle without ack
module wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic term_o
);

  // Count only ever spans 0..MAX_WAIT-1; the owner stops enabling at term_o.
  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CntLast);

endmodule

// File: rtl/cmp_branch_seq.sv
// Compare / conditional-branch sequencer for the accumulator datapath.
// Fetches an operand over the memory bus, presents AC and the operand to the
// external zero comparator, registers its result into Z and tells the PC
// whether to load the branch target.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : one-cycle request from the decoder (ignored while busy)
//   opcode_i       : 00 CMP, 01 JZ, 10 JNZ, 11 NOP
//   addr_i         : operand address
//   target_i       : branch target
//   ac_i           : accumulator value
//   mem            : memory read bus (master side)
//   cmp_r1_o/r2_o  : comparator operands (latched AC, latched operand)
//   cmp_z_i        : comparator zero result
//   z_flag_o       : registered Z flag
//   pc_load_o      : one-cycle pulse, PC loads pc_target_o
//   pc_target_o    : latched branch target
//   busy_o         : not idle
//   done_o         : one-cycle completion pulse
//   err_o          : one-cycle memory timeout pulse
module cmp_branch_seq
  import cmp_branch_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       opcode_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [AW-1:0]    target_i,
  input  logic [WIDTH-1:0] ac_i,
  cmp_branch_seq_if.master mem,
  output logic [WIDTH-1:0] cmp_r1_o,
  output logic [WIDTH-1:0] cmp_r2_o,
  input  logic             cmp_z_i,
  output logic             z_flag_o,
  output logic             pc_load_o,
  output logic [AW-1:0]    pc_target_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_d, state_q;
  logic [1:0]       op_d, op_q;
  logic [WIDTH-1:0] ac_d, ac_q;
  logic [WIDTH-1:0] operand_d, operand_q;
  logic [AW-1:0]    addr_d, addr_q;
  logic [AW-1:0]    target_d, target_q;
  logic             z_d, z_q;
  logic             nop_done_d, nop_done_q;
  logic             err_d, err_q;

  logic timer_en, timer_clr, timer_term;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (timer_en),
    .clr_i  (timer_clr),
    .term_o (timer_term)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ac_d       = ac_q;
    operand_d  = operand_q;
    addr_d     = addr_q;
    target_d   = target_q;
    z_d        = z_q;
    nop_done_d = 1'b0;
    err_d      = 1'b0;
    timer_en   = 1'b0;
    timer_clr  = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (opcode_i == OP_NOP) begin
            nop_done_d = 1'b1;
          end else begin
            op_d     = opcode_i;
            ac_d     = ac_i;
            addr_d   = addr_i;
            target_d = target_i;
            state_d  = StReq;
          end
        end
      end
      StReq: begin
        timer_clr = 1'b0;
        if (mem.mem_ack) begin
          operand_d = mem.mem_data;
          timer_clr = 1'b1;
          state_d   = StCmp;
        end else if (timer_term) begin
          // Timer is cleared on the way back through IDLE.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_en = 1'b1;
        end
      end
      StCmp: begin
        z_d     = cmp_z_i;
        state_d = StResolve;
      end
      StResolve: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= OP_NOP;
      ac_q       <= '0;
      operand_q  <= '0;
      addr_q     <= '0;
      target_q   <= '0;
      z_q        <= 1'b0;
      nop_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ac_q       <= ac_d;
      operand_q  <= operand_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      z_q        <= z_d;
      nop_done_q <= nop_done_d;
      err_q      <= err_d;
    end
  end

  // Every output is a register or a decode of registered state.
  assign mem.mem_req  = (state_q == StReq);
  assign mem.mem_addr = addr_q;
  assign cmp_r1_o     = ac_q;
  assign cmp_r2_o     = operand_q;
  assign z_flag_o     = z_q;
  assign pc_target_o  = target_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StResolve) || nop_done_q;
  assign pc_load_o    = (state_q == StResolve) && branch_taken(op_q, z_q);
  assign err_o        = err_q;

endmodule
